rng_stream_gen: RTL and testbench
=================================

# rng_stream_gen

Parametrised pseudo-random word generator. It is the successor to the fixed 8-bit RNG core behind the top-level pin wrapper. The block runs a Galois LFSR of configurable width and polynomial, serialises its output bit into words of configurable width, and presents them on a valid/ready stream. It adds free-run, on-demand and deterministic count modes, a seed-load strobe with zero-lockup guard, and a sticky overrun flag. It sits between the pin wrapper (mode/seed from `ui_in`) and any consumer of random words.

## Interface
- `WIDTH`, 16: LFSR state width, 4..32.
- `POLY`, 16'hB400: Galois feedback mask, WIDTH bits; the MSB must be set.
- `DEFAULT_SEED`, 16'hACE1: reset state, and the base value XORed with `seed`. Must be non-zero.
- `SEED_W`, 4: seed input width, ≤ WIDTH.
- `OUT_W`, 8: output word width, 2..WIDTH, power of two.
- `clk` in 1: clock. All logic is on the rising edge.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `mode` in 2: operating mode. 00 HALT, 01 FREE, 10 DEMAND, 11 COUNT.
- `seed` in SEED_W: seed value, zero-extended; sampled only when `seed_load` is high.
- `seed_load` in 1: single-cycle strobe that reseeds and flushes the block.
- `rnd_data` out OUT_W: output word, stable while `rnd_valid` is high and not accepted.
- `rnd_valid` out 1: output word is available.
- `rnd_ready` in 1: consumer accepts the word. Ignored when `rnd_valid` is low.
- `overrun` out 1: sticky flag, set when an unaccepted word is overwritten in FREE mode.

## Operation
- **Step, LFSR modes (FREE, DEMAND):**
  - `b = state[0]`.
  - `state = state >> 1`.
  - If `b` is 1, `state ^= POLY`.
- **Step, COUNT mode:**
  - `b = state[0]`.
  - `state = state + 1`, wrapping modulo 2^WIDTH.
- **Bit collection:** every step shifts the accumulator MSB-first: `acc = {acc[OUT_W-2:0], b}`. A `$clog2(OUT_W)`-bit counter tracks steps; a word is complete after OUT_W steps.
- **Seed load:**
  - `state = DEFAULT_SEED ^ zext(seed)`. If that result is 0, load 1 instead.
  - Clear `acc`, the step counter, `rnd_valid` and `overrun`.
  - No step occurs on the load edge.
  - `seed_load` has priority over every other event.
- **Internal FSM:**
  - FILL: step once per cycle.
  - HOLD: `acc` is full and the output register is occupied, so stepping stops. HOLD is reachable only in DEMAND or COUNT.
  - HALT: entered whenever `mode` is 00, from any state. Nothing steps, and `rnd_valid`/`rnd_data` keep their values. Accepts on `rnd_ready` are still honoured.
  - On leaving HALT, the FSM returns to FILL, or to HOLD if `acc` is full.
- **Word completion:**
  - Output register empty, or being accepted this cycle: `rnd_data <= acc_next` and `rnd_valid <= 1`.
  - FREE mode with the output register occupied and not accepted: overwrite `rnd_data`, keep `rnd_valid` high, set `overrun`. The LFSR never stalls in FREE.
  - DEMAND/COUNT with the output register occupied and not accepted: keep the full word in `acc` and go to HOLD. On the next accept, move `acc` into `rnd_data`, keep `rnd_valid` high, clear the step counter and return to FILL. This gives two-deep buffering.
- **Accept:** `rnd_valid && rnd_ready`. If no word completes and HOLD is not draining on that edge, `rnd_valid` drops to 0.
- **Mode change mid-word:** takes effect on the next edge. `acc` and the step counter are not reset, so the word can mix LFSR and count bits.

## Timing
- **Reset values:**
  - `state` = DEFAULT_SEED.
  - `acc`, step counter, `rnd_data` = 0.
  - `rnd_valid`, `overrun` = 0.
  - FSM in FILL, or HALT if `mode` is 00. Stepping starts on the first edge after reset release.
- **Latency:** `seed_load` is sampled at edge E0. Steps occur on E1..E_OUT_W, and `rnd_valid` is high after edge E_OUT_W.
- **Throughput:** one word per OUT_W cycles in FREE mode, and in DEMAND with `rnd_ready` tied high.
- **Accept and completion on the same edge:** `rnd_valid` stays 1 and the new word appears with no bubble.
- **Reset asserted mid-word:** all registers return to their reset values immediately (asynchronous). The partial word is lost.

## Structure
- **Package `rng_pkg`:**
  - `rng_mode_t` enum: `RNG_HALT`, `RNG_FREE`, `RNG_DEMAND`, `RNG_COUNT`.
  - FSM state enum.
  - Polynomial constants `RNG_POLY8`, `RNG_POLY16`, `RNG_POLY32`.
  - `RNG_SEED_DEFAULT`.
- **Sub-module `rng_lfsr_step`:** combinational, parametrised by WIDTH, POLY and count-enable. Inputs `state`; outputs `next_state` and `out_bit`.
- **Top-level wrapper:** instantiates the block with WIDTH=16, OUT_W=8, SEED_W=4. It maps `ui_in[5:4]` to `mode` and `ui_in[3:0]` to `seed`, and drives `seed_load` from a synchronised pin edge.

## Test plan
- **Reset defaults:** reset with `mode`=01. Required: all outputs 0 during reset; `rnd_valid` rises exactly 8 cycles after release.
- **Zero-seed guard and LFSR sequence:** override DEFAULT_SEED=16'h0001, `seed`=4'h1, pulse `seed_load`, `mode`=10, `rnd_ready`=1. Required:
  - state is forced to 16'h0001;
  - the step sequence is B400, 5A00, 2D00, …;
  - the first word is 8'h80, valid 8 cycles after the load.
- **COUNT mode:** default parameters, `seed`=0, `mode`=11. Required: state 16'hACE1, then 8'hAA on consecutive words; after two words, state = 16'hACF1.
- **DEMAND backpressure:** `rnd_ready`=0 for 30 cycles. Required:
  - `rnd_data` holds the first word;
  - the FSM reaches HOLD at cycle 16;
  - `overrun` stays 0;
  - raising `rnd_ready` delivers the second word with no gap, then the next word 8 cycles later.
- **FREE overrun:** `mode`=01, `rnd_ready`=0. Required: `rnd_data` is replaced at cycle 16; `overrun`=1 stays set through accepts; a `seed_load` clears it.
- **Simultaneous events:** `seed_load` on the same edge as a word completion and an accept. Required: load wins, `rnd_valid`=0, no word is emitted. Separately, `mode`=00 mid-word: the step counter freezes, and the word resumes and completes after `mode` returns to a running mode.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared types and constants for the random word stream generator.
package rng_pkg;

  typedef enum logic [1:0] {
    RNG_HALT   = 2'b00,
    RNG_FREE   = 2'b01,
    RNG_DEMAND = 2'b10,
    RNG_COUNT  = 2'b11
  } rng_mode_t;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HOLD = 2'd1,
    ST_HALT = 2'd2
  } rng_fsm_t;

  // Galois feedback masks (MSB set) for common widths.
  localparam logic [7:0]  RNG_POLY8        = 8'hB8;
  localparam logic [15:0] RNG_POLY16       = 16'hB400;
  localparam logic [31:0] RNG_POLY32       = 32'h8020_0003;
  localparam logic [15:0] RNG_SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/rng_lfsr_step.sv
// One combinational step of the generator: Galois LFSR shift or binary count.
module rng_lfsr_step #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY = 16'hB400
) (
  input  logic [WIDTH-1:0] state,
  input  logic             count_en,
  output logic [WIDTH-1:0] next_state,
  output logic             out_bit
);

  assign out_bit = state[0];

  always_comb begin
    if (count_en) next_state = state + WIDTH'(1);
    else          next_state = (state >> 1) ^ (state[0] ? POLY : '0);
  end

endmodule

// File: rtl/rng_stream_gen.sv
// Random word generator: steps an LFSR/counter, packs bits MSB-first into
// OUT_W-bit words and offers them on a valid/ready stream with a one-word skid.
module rng_stream_gen
  import rng_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] POLY         = RNG_POLY16,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = RNG_SEED_DEFAULT,
  parameter int               SEED_W       = 4,
  parameter int               OUT_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [SEED_W-1:0] seed,
  input  logic              seed_load,
  output logic [OUT_W-1:0]  rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              overrun
);

  localparam int               CNT_W    = $clog2(OUT_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

  rng_mode_t        mode_e;
  rng_fsm_t         fsm_q, fsm_d, fsm_act;
  logic [WIDTH-1:0] state, step_state, seed_mix, seed_state;
  logic             step_bit;
  logic [OUT_W-1:0] acc, acc_next;
  logic [CNT_W-1:0] cnt;
  logic             full_q;
  logic             accept, step, wrap, drain, emit, park, ovr_set;

  assign mode_e     = rng_mode_t'(mode);
  assign seed_mix   = DEFAULT_SEED ^ WIDTH'(seed);
  assign seed_state = (seed_mix == '0) ? WIDTH'(1) : seed_mix;
  assign acc_next   = {acc[OUT_W-2:0], step_bit};

  rng_lfsr_step #(.WIDTH(WIDTH), .POLY(POLY)) u_step (
    .state      (state),
    .count_en   (mode_e == RNG_COUNT),
    .next_state (step_state),
    .out_bit    (step_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= ST_FILL;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    // A halted mode overrides the stored state for this edge; leaving HALT
    // resumes HOLD if a parked word is still waiting in acc.
    fsm_act = fsm_q;
    if (mode_e == RNG_HALT)   fsm_act = ST_HALT;
    else if (fsm_q == ST_HALT) fsm_act = full_q ? ST_HOLD : ST_FILL;

    accept  = rnd_valid && rnd_ready;
    step    = (fsm_act == ST_FILL);
    wrap    = step && (cnt == CNT_LAST);
    drain   = full_q && accept;
    emit    = wrap && (!rnd_valid || accept || mode_e == RNG_FREE);
    ovr_set = wrap && rnd_valid && !accept && (mode_e == RNG_FREE);
    park    = wrap && !emit;

    fsm_d = fsm_act;
    if (seed_load)                          fsm_d = (mode_e == RNG_HALT) ? ST_HALT : ST_FILL;
    else if (park)                          fsm_d = ST_HOLD;
    else if (drain && fsm_act == ST_HOLD)   fsm_d = ST_FILL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DEFAULT_SEED;
      acc       <= '0;
      cnt       <= '0;
      rnd_data  <= '0;
      rnd_valid <= 1'b0;
      overrun   <= 1'b0;
      full_q    <= 1'b0;
    end else if (seed_load) begin
      state     <= seed_state;
      acc       <= '0;
      cnt       <= '0;
      rnd_valid <= 1'b0;
      overrun   <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      if (step) begin
        state <= step_state;
        acc   <= acc_next;
        cnt   <= cnt + CNT_W'(1);
      end
      if (emit) begin
        rnd_data  <= acc_next;
        rnd_valid <= 1'b1;
      end else if (drain) begin
        rnd_data  <= acc;
        rnd_valid <= 1'b1;
        full_q    <= 1'b0;
        cnt       <= '0;
      end else if (accept) begin
        rnd_valid <= 1'b0;
      end
      if (park)    full_q  <= 1'b1;
      if (ovr_set) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rng_stream_gen.sv
// Self-checking bench: directed tables and sequences plus randomized traffic
// against a word-queue reference model of the generator.
module tb_rng_stream_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'b01;
  logic [3:0] seed = 4'h0;
  logic       seed_load = 1'b0;
  logic       rnd_ready = 1'b0;
  logic [7:0] rnd_data, z_data;
  logic       rnd_valid, overrun, z_valid, z_ovr;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rng_stream_gen dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .seed(seed), .seed_load(seed_load),
    .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .overrun(overrun)
  );

  rng_stream_gen #(.DEFAULT_SEED(16'h0001)) dut_z (
    .clk(clk), .rst_n(rst_n), .mode(mode), .seed(seed), .seed_load(seed_load),
    .rnd_data(z_data), .rnd_valid(z_valid), .rnd_ready(rnd_ready), .overrun(z_ovr)
  );

  // Reference model: generator state, partial word, and a queue of finished
  // words (front = presented word, second entry = parked word).
  int unsigned m_state;
  logic [7:0]  m_part;
  int          m_n;
  bit          m_ovr;
  logic [7:0]  m_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 32'hACE1;
    m_part  = '0;
    m_n     = 0;
    m_ovr   = 0;
    m_q.delete();
  endtask

  task automatic model_edge();
    bit acc_ok, can, b;
    if (seed_load) begin
      m_state = 32'hACE1 ^ 32'(seed);
      if (m_state == 0) m_state = 1;
      m_part = '0;
      m_n    = 0;
      m_ovr  = 0;
      m_q.delete();
      return;
    end
    acc_ok = (m_q.size() > 0) && rnd_ready;
    can    = (mode != 2'b00) && (m_q.size() < 2);
    if (acc_ok) void'(m_q.pop_front());
    if (can) begin
      b = m_state[0];
      if (mode == 2'b11) m_state = (m_state + 1) % 65536;
      else m_state = (m_state >> 1) ^ (b ? 32'hB400 : 32'h0);
      m_part = {m_part[6:0], b};
      m_n++;
      if (m_n == 8) begin
        m_n = 0;
        if (m_q.size() == 0)   m_q.push_back(m_part);
        else if (mode == 2'b01) begin
          m_q[m_q.size()-1] = m_part;
          m_ovr = 1;
        end else m_q.push_back(m_part);
      end
    end
  endtask

  task automatic compare_model();
    chk("valid", rnd_valid, (m_q.size() > 0));
    if (m_q.size() > 0) chk("data", rnd_data, m_q[0]);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic load(input logic [3:0] s, input logic [1:0] m, input logic rdy);
    seed = s; mode = m; rnd_ready = rdy; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  typedef struct {
    logic [3:0] seed;
    logic [1:0] mode;
    logic [7:0] w1;
    logic [7:0] w2;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{4'h0, 2'b11, 8'hAA, 8'hAA};
    tbl[1] = '{4'h1, 2'b11, 8'h55, 8'h55};
    tbl[2] = '{4'hE, 2'b11, 8'hAA, 8'hAA};
    tbl[3] = '{4'hF, 2'b11, 8'h55, 8'h55};

    // Reset defaults with FREE mode selected
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", rnd_valid, 1'b0);
    chk("rst_data", rnd_data, 8'h00);
    chk("rst_ovr", overrun, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("rst_lat_lo", rnd_valid, 1'b0);
    tick();
    chk("rst_lat_hi", rnd_valid, 1'b1);

    // COUNT-mode table: alternating LSBs give AA or 55 depending on seed parity
    for (int v = 0; v < 4; v++) begin
      load(tbl[v].seed, tbl[v].mode, 1'b1);
      for (int i = 0; i < 7; i++) tick();
      chk("tbl_lat", rnd_valid, 1'b0);
      tick();
      chk("tbl_v1", rnd_valid, 1'b1);
      chk("tbl_w1", rnd_data, tbl[v].w1);
      for (int i = 0; i < 8; i++) tick();
      chk("tbl_v2", rnd_valid, 1'b1);
      chk("tbl_w2", rnd_data, tbl[v].w2);
    end

    // Zero-seed guard on the DEFAULT_SEED=1 instance
    load(4'h1, 2'b10, 1'b1);
    for (int i = 0; i < 7; i++) tick();
    chk("zg_lat", z_valid, 1'b0);
    tick();
    chk("zg_v1", z_valid, 1'b1);
    chk("zg_w1", z_data, 8'h80);
    for (int i = 0; i < 8; i++) tick();
    chk("zg_w2", z_data, 8'h16);
    chk("zg_ovr", z_ovr, 1'b0);

    // DEMAND backpressure: two words buffered, then drained with no gap
    load(4'h3, 2'b10, 1'b0);
    for (int i = 0; i < 30; i++) tick();
    chk("bp_valid", rnd_valid, 1'b1);
    chk("bp_ovr", overrun, 1'b0);
    rnd_ready = 1'b1;
    tick();
    chk("bp_nogap", rnd_valid, 1'b1);
    for (int i = 0; i < 7; i++) tick();
    chk("bp_gap", rnd_valid, 1'b0);
    tick();
    chk("bp_w3", rnd_valid, 1'b1);

    // FREE overrun: sticky through accepts, cleared by seed load
    load(4'h5, 2'b01, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    chk("fr_ovr0", overrun, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    chk("fr_ovr1", overrun, 1'b1);
    rnd_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("fr_sticky", overrun, 1'b1);
    load(4'h5, 2'b01, 1'b0);
    chk("fr_clr", overrun, 1'b0);

    // Seed load colliding with word completion and accept
    load(4'h2, 2'b10, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    rnd_ready = 1'b1;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    chk("sim_valid", rnd_valid, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    chk("sim_lat", rnd_valid, 1'b0);
    tick();
    chk("sim_v", rnd_valid, 1'b1);

    // HALT mid-word freezes progress
    load(4'h6, 2'b10, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    mode = 2'b00;
    for (int i = 0; i < 5; i++) tick();
    chk("halt_frozen", rnd_valid, 1'b0);
    mode = 2'b10;
    for (int i = 0; i < 4; i++) tick();
    chk("halt_res_lo", rnd_valid, 1'b0);
    tick();
    chk("halt_res_hi", rnd_valid, 1'b1);

    // Randomized traffic with one asynchronous reset mid-run
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      rnd_ready = ($urandom_range(0, 2) != 0);
      seed      = 4'($urandom_range(0, 15));
      seed_load = ($urandom_range(0, 59) == 0);
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", rnd_valid, 1'b0);
        chk("arst_data", rnd_data, 8'h00);
        chk("arst_ovr", overrun, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
